// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch_entry_t with same-cycle push/pop at any occupancy
// and a synchronous flush that empties it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; readers qualify rdata with empty/count instead.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential address generation, credit-limited imem requests, redirect flush.
// Define FETCHQ_BYPASS_EN to forward a response straight to the datapath when the queue is empty.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] occ;
  logic [CW-1:0] sh_count;
  logic          req_fire;
  logic          rsp_take;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  logic          q_full;
  logic          sh_empty;
  logic          sh_full;
  fetch_entry_t  q_head;
  fetch_entry_t  q_wdata;
  fetch_entry_t  sh_head;
  fetch_entry_t  sh_wdata;

  // Credits cover both queued words and words still owed by memory, so a push never overflows.
  assign imem_req_valid = (state != BOOT) && !redirect && ((occ + inflight) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when no stale words are owed and no redirect is flushing this cycle.
  assign rsp_take = imem_rsp_valid && (drop == '0) && !redirect;
  assign sh_wdata = '{instr: '0, pc: fetch_pc};
  assign q_wdata  = '{instr: imem_rsp_data, pc: sh_head.pc};
  assign q_pop    = instr_ready && !q_empty;

`ifdef FETCHQ_BYPASS_EN
  logic byp;

  assign byp    = rsp_take && q_empty;
  assign q_push = rsp_take && !(byp && instr_ready);

  always_comb begin
    instr_valid = !q_empty || byp;
    instr       = '0;
    instr_pc    = '0;
    if (!q_empty) begin
      instr    = q_head.instr;
      instr_pc = q_head.pc;
    end else if (byp) begin
      instr    = imem_rsp_data;
      instr_pc = sh_head.pc;
    end
  end
`else
  assign q_push      = rsp_take;
  assign instr_valid = !q_empty;
  assign instr       = q_empty ? '0 : q_head.instr;
  assign instr_pc    = q_empty ? '0 : q_head.pc;
`endif

  // Redirect owes every in-flight word except one landing in the same cycle, which dies here.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    drop_next = drop;
    if (redirect)                               drop_next = inflight - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop != '0))    drop_next = drop - CW'(1);
    state_next = (drop_next != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state    <= state_next;
      drop     <= drop_next;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect)      fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_instr_q (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (q_push),
    .wdata   (q_wdata),
    .pop     (q_pop),
    .flush   (redirect),
    .rdata   (q_head),
    .count   (occ),
    .full    (q_full),
    .empty   (q_empty)
  );

  // PC shadow: one entry per live request, consumed by the response it belongs to.
  fetch_fifo #(.DEPTH(DEPTH)) u_pc_shadow (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (req_fire),
    .wdata   (sh_wdata),
    .pop     (rsp_take),
    .flush   (redirect),
    .rdata   (sh_head),
    .count   (sh_count),
    .full    (sh_full),
    .empty   (sh_empty)
  );

  logic unused_sigs;
  assign unused_sigs = ^{q_full, sh_count, sh_full, sh_empty, sh_head.instr, redirect_pc[1:0]};

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the single-cycle datapath.
- Generates sequential instruction addresses and issues them to a variable-latency instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers up to DEPTH fetched words and presents {instr, instr_pc} to the datapath with a valid/ready handshake.
- Redirect (taken branch, j, jal, jr) flushes queued and in-flight fetches and restarts at the target.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- imem_req_valid  out  1  request address valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in request order, latency >= 1 cycle.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  datapath consumes head.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of head instruction.

Behaviour:
- Reset (asynchronous assert, synchronous release): fetch_pc=RESET_PC, queue empty, inflight=0, drop=0, state=BOOT.
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- FSM states:
  - BOOT: one cycle, no request; then RUN.
  - RUN: normal fetch.
  - FLUSH: drop>0; responses are discarded, new requests are still allowed. Returns to RUN when drop reaches 0.
- Credits:
  - imem_req_valid = (state!=BOOT) & !redirect & (occupancy + inflight < DEPTH).
  - imem_req_addr = fetch_pc.
  - On request handshake: fetch_pc += 4, wrapping mod 2^32; inflight++.
- Response handling:
  - inflight-- on each response.
  - If drop>0: drop--, word discarded.
  - Otherwise: word pushed with its PC, taken from a PC shadow FIFO (depth DEPTH) written at request time.
- Head/pop:
  - instr, instr_pc and instr_valid are registered from the queue head.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are allowed at any occupancy; the credit rule prevents overflow.
- Redirect (highest priority):
  - Next cycle: queue empty, instr_valid=0, fetch_pc=redirect_pc&~3.
  - drop = inflight minus any response arriving in the redirect cycle; that response is discarded.
  - State goes to FLUSH if the new drop>0, else RUN.
  - A pop in the redirect cycle is still honoured (the datapath consumed the branch).
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: each one recomputes drop from the current inflight.
- Latency: an empty queue with a 1-cycle memory gives instr_valid 2 cycles after the request handshake.
- Counters are log2(DEPTH)+1 bits wide and never exceed DEPTH.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- With the macro defined:
  - When the queue is empty, drop==0, no redirect, and imem_rsp_valid is high, instr and instr_pc are driven combinationally from the response and instr_valid=1 in the same cycle.
  - If instr_ready is also high, the word is not enqueued. Empty-queue latency drops by 1.
- Without the macro: all outputs are registered as above.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_state_t {BOOT, RUN, FLUSH}.
  - constant PC_STEP=32'd4.
  - typedef fetch_entry_t {instr[31:0], pc[31:0]}.
- One sub-module, fetch_fifo: a parameterised DEPTH x fetch_entry_t circular buffer with push, pop, flush, count and full/empty. It is instantiated twice: the instruction queue and the PC shadow FIFO.

Test Plan:
- Reset, 1-cycle memory, instr_ready=1: requests 0x0, 0x4, 0x8 in consecutive cycles. instr_valid first rises 2 cycles after the first handshake with instr_pc=0x0, then a new word every cycle.
- instr_ready=0, DEPTH=4, memory always ready: exactly 4 requests issued (0x0..0xC), then imem_req_valid=0. One pop causes exactly one new request, 0x10.
- 3-cycle memory, redirect to 0x40 while 2 requests are in flight: both stale responses are discarded (state FLUSH). The first delivered instr_pc is 0x40, and no 0x8/0xC words appear.
- Redirect asserted in the same cycle as imem_rsp_valid and pop: the pop completes, the response is discarded, drop=inflight-1, and the next request address is the target.
- redirect_pc=0x103: imem_req_addr=0x100. Sequential fetch from 0xFFFF_FFFC wraps to 0x0000_0000.
- FETCHQ_BYPASS_EN defined, empty queue, 1-cycle memory: instr_valid rises in the cycle imem_rsp_valid=1 with instr=imem_rsp_data, and occupancy stays 0.
